// File: rtl/sram_fill_engine.sv
// Pattern fill engine for a single-port SRAM: writes seed or seed+index, optionally reads back and compares.
// Optional feature macro: SRAM_FILL_VERIFY_EN enables the VERIFY/DRAIN read-back and compare path.
module sram_fill_engine #(
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 10240,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic [DATA_W-1:0] pattern_seed,
  input  logic              pattern_mode,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] err_addr,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] sram_address,
  output logic [3:0]        sram_byteenable,
  output logic              sram_chipselect,
  output logic              sram_write,
  output logic              sram_clken,
  output logic [DATA_W-1:0] sram_writedata,
  input  logic [DATA_W-1:0] sram_readdata
);

  typedef enum logic [2:0] {IDLE, FILL, VERIFY, DRAIN, DONE} state_t;

  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

`ifdef SRAM_FILL_VERIFY_EN
  localparam state_t FILL_EXIT = VERIFY;
`else
  localparam state_t FILL_EXIT = DONE;
`endif

  state_t state, state_next;

  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   count_q;
  logic [DATA_W-1:0] seed_q;
  logic              mode_q;
  logic [ADDR_W:0]   idx;

  logic [ADDR_W+1:0] job_end;
  logic              job_empty;
  logic              job_oob;
  logic [ADDR_W-1:0] addr_now;
  logic [DATA_W-1:0] pattern_now;
  logic              last_word;

  // Range check is one bit wider than base+count can ever reach, so it cannot wrap.
  assign job_end     = {2'b00, base_addr} + {1'b0, word_count};
  assign job_empty   = (word_count == '0);
  assign job_oob     = (job_end > (ADDR_W+2)'(DEPTH));
  assign addr_now    = base_q + idx[ADDR_W-1:0];
  assign pattern_now = mode_q ? (seed_q + DATA_W'(idx)) : seed_q;
  assign last_word   = ((idx + ONE) == count_q);

  assign sram_byteenable = 4'b1111;
  assign sram_clken      = 1'b1;

`ifdef SRAM_FILL_VERIFY_EN
  logic              cmp_valid;
  logic [ADDR_W-1:0] cmp_addr;
  logic [DATA_W-1:0] cmp_expect;
  logic              mismatch;

  assign mismatch = cmp_valid && (sram_readdata != cmp_expect);
`else
  logic unused_readdata;

  assign unused_readdata = ^sram_readdata;
  assign err_count       = '0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (job_empty || job_oob) ? DONE : FILL;
      FILL:    if (!hold && last_word) state_next = FILL_EXIT;
`ifdef SRAM_FILL_VERIFY_EN
      VERIFY:  if (!hold && last_word) state_next = DRAIN;
      DRAIN:   state_next = DONE;
`endif
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy            = 1'b0;
    done            = 1'b0;
    sram_chipselect = 1'b0;
    sram_write      = 1'b0;
    sram_address    = '0;
    sram_writedata  = '0;
    case (state)
      FILL: begin
        busy = 1'b1;
        if (!hold) begin
          sram_chipselect = 1'b1;
          sram_write      = 1'b1;
          sram_address    = addr_now;
          sram_writedata  = pattern_now;
        end
      end
`ifdef SRAM_FILL_VERIFY_EN
      VERIFY: begin
        busy = 1'b1;
        if (!hold) begin
          sram_chipselect = 1'b1;
          sram_address    = addr_now;
        end
      end
      DRAIN:   busy = 1'b1;
`endif
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base_q     <= '0;
      count_q    <= '0;
      seed_q     <= '0;
      mode_q     <= 1'b0;
      idx        <= '0;
      error      <= 1'b0;
      err_addr   <= '0;
`ifdef SRAM_FILL_VERIFY_EN
      err_count  <= '0;
      cmp_valid  <= 1'b0;
      cmp_addr   <= '0;
      cmp_expect <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base_q   <= base_addr;
            count_q  <= word_count;
            seed_q   <= pattern_seed;
            mode_q   <= pattern_mode;
            idx      <= '0;
            error    <= job_oob;
            err_addr <= job_oob ? base_addr : '0;
`ifdef SRAM_FILL_VERIFY_EN
            err_count <= '0;
`endif
          end
        end
        FILL: begin
          if (!hold) idx <= last_word ? '0 : idx + ONE;
        end
`ifdef SRAM_FILL_VERIFY_EN
        VERIFY: begin
          if (!hold) idx <= idx + ONE;
        end
`endif
        default: ;
      endcase

`ifdef SRAM_FILL_VERIFY_EN
      // Read data arrives one cycle after the read; the compare runs regardless of hold.
      cmp_valid  <= (state == VERIFY) && !hold;
      cmp_addr   <= addr_now;
      cmp_expect <= pattern_now;
      if (mismatch) begin
        if (err_count != '1) err_count <= err_count + ONE;
        if (!error) begin
          error    <= 1'b1;
          err_addr <= cmp_addr;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_sram_fill_engine.sv
// Scoreboard bench for sram_fill_engine: expected SRAM accesses are queued per job and compared in order.
module tb_sram_fill_engine;
  localparam int ADDR_W = 14;
  localparam int DEPTH  = 10240;
  localparam int DATA_W = 32;
`ifdef SRAM_FILL_VERIFY_EN
  localparam bit VERIFY_ON = 1'b1;
`else
  localparam bit VERIFY_ON = 1'b0;
`endif

  logic              clk          = 1'b0;
  logic              reset        = 1'b1;
  logic              start        = 1'b0;
  logic [ADDR_W-1:0] base_addr    = '0;
  logic [ADDR_W:0]   word_count   = '0;
  logic [DATA_W-1:0] pattern_seed = '0;
  logic              pattern_mode = 1'b0;
  logic              hold         = 1'b0;
  logic              busy, done, error;
  logic [ADDR_W-1:0] err_addr;
  logic [ADDR_W:0]   err_count;
  logic [ADDR_W-1:0] sram_address;
  logic [3:0]        sram_byteenable;
  logic              sram_chipselect, sram_write, sram_clken;
  logic [DATA_W-1:0] sram_writedata;
  logic [DATA_W-1:0] sram_readdata;

  sram_fill_engine #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .word_count(word_count),
    .pattern_seed(pattern_seed), .pattern_mode(pattern_mode), .hold(hold),
    .busy(busy), .done(done), .error(error), .err_addr(err_addr), .err_count(err_count),
    .sram_address(sram_address), .sram_byteenable(sram_byteenable),
    .sram_chipselect(sram_chipselect), .sram_write(sram_write), .sram_clken(sram_clken),
    .sram_writedata(sram_writedata), .sram_readdata(sram_readdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } acc_t;

  acc_t exp_q[$];
  acc_t obs_q[$];
  int   checks    = 0;
  int   failures  = 0;
  int   done_seen = 0;

  // SRAM model with one-cycle read latency and an optional single corrupted word on read.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic              corrupt_en   = 1'b0;
  logic [ADDR_W-1:0] corrupt_addr = '0;

  always @(posedge clk) begin
    if (sram_chipselect && sram_write) mem[sram_address] <= sram_writedata;
    if (sram_chipselect && !sram_write)
      sram_readdata <= (corrupt_en && sram_address == corrupt_addr) ?
                       (mem[sram_address] ^ 32'h1) : mem[sram_address];
  end

  // Called 2 time units after a rising edge; samples 1 unit later, then advances one cycle.
  task automatic tick();
    acc_t a;
    #1;
    if (sram_chipselect) begin
      a.wr   = sram_write;
      a.addr = sram_address;
      a.data = sram_writedata;
      obs_q.push_back(a);
    end
    if (done) done_seen++;
    @(posedge clk);
    #2;
  endtask

  task automatic push_expect(input logic [ADDR_W-1:0] b, input int n,
                             input logic [DATA_W-1:0] s, input logic m);
    acc_t a;
    for (int i = 0; i < n; i++) begin
      a.wr   = 1'b1;
      a.addr = b + ADDR_W'(i);
      a.data = m ? (s + DATA_W'(i)) : s;
      exp_q.push_back(a);
    end
    if (VERIFY_ON) begin
      for (int i = 0; i < n; i++) begin
        a.wr   = 1'b0;
        a.addr = b + ADDR_W'(i);
        a.data = '0;
        exp_q.push_back(a);
      end
    end
  endtask

  task automatic run_job(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] n,
                         input logic [DATA_W-1:0] s, input logic m,
                         input int hold_from, input int hold_len, input bit keep_start,
                         output int cycles, output bit timed_out);
    base_addr    = b;
    word_count   = n;
    pattern_seed = s;
    pattern_mode = m;
    start        = 1'b1;
    done_seen    = 0;
    obs_q.delete();
    tick();
    start = keep_start;
    if (keep_start) begin
      base_addr    = ~b;
      word_count   = n + 3;
      pattern_seed = ~s;
      pattern_mode = ~m;
    end
    timed_out = 1'b1;
    cycles    = 0;
    for (int k = 1; k <= 200; k++) begin
      hold = (k >= hold_from) && (k < hold_from + hold_len);
      tick();
      if (done_seen != 0) begin
        cycles    = k;
        timed_out = 1'b0;
        break;
      end
    end
    hold  = 1'b0;
    start = 1'b0;
  endtask

  function automatic int job_len(input int n);
    return VERIFY_ON ? (2 * n + 2) : (n + 1);
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    repeat (3) tick();
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++;
      $display("FAIL reset_status busy=%b done=%b want 0 0", busy, done); end
    checks++; if (error !== 1'b0 || err_addr !== '0 || err_count !== '0) begin failures++;
      $display("FAIL reset_error error=%b err_addr=%h err_count=%h want 0", error, err_addr, err_count); end
    checks++; if (sram_chipselect !== 1'b0 || sram_write !== 1'b0 || sram_address !== '0 || sram_writedata !== '0) begin
      failures++; $display("FAIL reset_sram cs=%b wr=%b addr=%h wdata=%h want 0", sram_chipselect, sram_write, sram_address, sram_writedata); end
    checks++; if (sram_byteenable !== 4'b1111 || sram_clken !== 1'b1) begin failures++;
      $display("FAIL reset_const be=%b clken=%b want 1111 1", sram_byteenable, sram_clken); end
    reset = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #2;
    obs_q.delete();
  endtask

  task automatic test_basic();
    int cyc; bit to; acc_t e, o;
    push_expect(14'h0100, 4, 32'hA000_0000, 1'b1);
    run_job(14'h0100, 15'd4, 32'hA000_0000, 1'b1, 0, 0, 1'b0, cyc, to);
    repeat (2) tick();
    checks++; if (to !== 1'b0 || cyc != job_len(4)) begin failures++;
      $display("FAIL basic_length cycles=%0d want=%0d timeout=%b", cyc, job_len(4), to); end
    checks++; if (done_seen != 1) begin failures++; $display("FAIL basic_done_pulses got=%0d want=1", done_seen); end
    checks++; if (obs_q.size() != exp_q.size()) begin failures++;
      $display("FAIL basic_access_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.wr !== e.wr || o.addr !== e.addr || (e.wr && o.data !== e.data)) begin failures++;
        $display("FAIL basic_access got wr=%b addr=%h data=%h want wr=%b addr=%h data=%h", o.wr, o.addr, o.data, e.wr, e.addr, e.data); end
    end
    checks++; if (error !== 1'b0 || err_count !== '0 || busy !== 1'b0) begin failures++;
      $display("FAIL basic_status error=%b err_count=%0d busy=%b want 0 0 0", error, err_count, busy); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_corrupt();
    int cyc; bit to;
    corrupt_en   = 1'b1;
    corrupt_addr = 14'h0102;
    run_job(14'h0100, 15'd4, 32'hA000_0000, 1'b1, 0, 0, 1'b0, cyc, to);
    corrupt_en = 1'b0;
    checks++; if (to !== 1'b0 || done_seen != 1) begin failures++;
      $display("FAIL corrupt_done timeout=%b done_pulses=%0d want 0 1", to, done_seen); end
    repeat (3) tick();
    checks++; if (error !== 1'b1 || err_addr !== 14'h0102 || err_count !== 15'd1) begin failures++;
      $display("FAIL corrupt_error error=%b err_addr=%h err_count=%0d want 1 0102 1", error, err_addr, err_count); end
    obs_q.delete();
  endtask

  task automatic test_hold();
    int c0, c1; bit to0, to1; acc_t e, o;
    push_expect(14'h0200, 8, 32'h1234_0000, 1'b1);
    run_job(14'h0200, 15'd8, 32'h1234_0000, 1'b1, 0, 0, 1'b0, c0, to0);
    obs_q.delete();
    run_job(14'h0200, 15'd8, 32'h1234_0000, 1'b1, 4, 3, 1'b0, c1, to1);
    checks++; if (to0 !== 1'b0 || to1 !== 1'b0 || c1 != c0 + 3 || c1 != job_len(8) + 3) begin failures++;
      $display("FAIL hold_length plain=%0d held=%0d want %0d %0d", c0, c1, job_len(8), job_len(8) + 3); end
    checks++; if (obs_q.size() != exp_q.size()) begin failures++;
      $display("FAIL hold_access_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.wr !== e.wr || o.addr !== e.addr || (e.wr && o.data !== e.data)) begin failures++;
        $display("FAIL hold_access got wr=%b addr=%h data=%h want wr=%b addr=%h data=%h", o.wr, o.addr, o.data, e.wr, e.addr, e.data); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_out_of_range();
    int cyc; bit to;
    run_job(14'd10238, 15'd3, 32'h0, 1'b0, 0, 0, 1'b0, cyc, to);
    checks++; if (to !== 1'b0 || cyc != 1) begin failures++;
      $display("FAIL oob_done_latency cycles=%0d want=1 timeout=%b", cyc, to); end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL oob_accesses got=%0d want=0", obs_q.size()); end
    repeat (3) tick();
    checks++; if (error !== 1'b1 || err_addr !== 14'd10238 || err_count !== '0) begin failures++;
      $display("FAIL oob_error error=%b err_addr=%0d err_count=%0d want 1 10238 0", error, err_addr, err_count); end
    obs_q.delete();
  endtask

  task automatic test_zero_count();
    int cyc; bit to;
    run_job(14'h0050, 15'd0, 32'hFFFF_FFFF, 1'b1, 0, 0, 1'b0, cyc, to);
    repeat (2) tick();
    checks++; if (to !== 1'b0 || cyc != 1 || done_seen != 1) begin failures++;
      $display("FAIL zero_done cycles=%0d pulses=%0d want 1 1", cyc, done_seen); end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL zero_accesses got=%0d want=0", obs_q.size()); end
    checks++; if (error !== 1'b0 || err_addr !== '0) begin failures++;
      $display("FAIL zero_error error=%b err_addr=%h want 0 0", error, err_addr); end
    obs_q.delete();
  endtask

  task automatic test_boundary_fit();
    int cyc; bit to; acc_t e, o;
    push_expect(14'd10237, 3, 32'h5A5A_0F0F, 1'b0);
    run_job(14'd10237, 15'd3, 32'h5A5A_0F0F, 1'b0, 0, 0, 1'b0, cyc, to);
    checks++; if (to !== 1'b0 || cyc != job_len(3) || error !== 1'b0) begin failures++;
      $display("FAIL fit_job cycles=%0d error=%b want %0d 0", cyc, error, job_len(3)); end
    checks++; if (obs_q.size() != exp_q.size()) begin failures++;
      $display("FAIL fit_access_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.wr !== e.wr || o.addr !== e.addr || (e.wr && o.data !== e.data)) begin failures++;
        $display("FAIL fit_access got wr=%b addr=%h data=%h want wr=%b addr=%h data=%h", o.wr, o.addr, o.data, e.wr, e.addr, e.data); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    int c0, c1; bit to0, to1; acc_t e, o;
    push_expect(14'h0300, 5, 32'h0000_00FF, 1'b1);
    run_job(14'h0300, 15'd5, 32'h0000_00FF, 1'b1, 0, 0, 1'b1, c0, to0);
    push_expect(14'h0310, 2, 32'hDEAD_BEEF, 1'b0);
    run_job(14'h0310, 15'd2, 32'hDEAD_BEEF, 1'b0, 0, 0, 1'b0, c1, to1);
    obs_q.push_front(obs_q[0]);
    void'(obs_q.pop_front());
    checks++; if (to0 !== 1'b0 || to1 !== 1'b0 || c0 != job_len(5) || c1 != job_len(2)) begin failures++;
      $display("FAIL b2b_length c0=%0d c1=%0d want %0d %0d", c0, c1, job_len(5), job_len(2)); end
    // The first job's accesses were cleared by the second run_job; re-check the second job only.
    repeat (5) void'(exp_q.pop_front());
    if (VERIFY_ON) repeat (5) void'(exp_q.pop_front());
    checks++; if (obs_q.size() != exp_q.size()) begin failures++;
      $display("FAIL b2b_access_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.wr !== e.wr || o.addr !== e.addr || (e.wr && o.data !== e.data)) begin failures++;
        $display("FAIL b2b_access got wr=%b addr=%h data=%h want wr=%b addr=%h data=%h", o.wr, o.addr, o.data, e.wr, e.addr, e.data); end
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (mem[14'h0300 + ADDR_W'(i)] !== 32'h0000_00FF + DATA_W'(i)) begin failures++;
        $display("FAIL b2b_first_job_mem addr=%h got=%h want=%h", 14'h0300 + ADDR_W'(i), mem[14'h0300 + ADDR_W'(i)], 32'h0000_00FF + DATA_W'(i)); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid_job();
    int cyc; bit to; int r_tick;
    r_tick = VERIFY_ON ? 6 : 2;
    base_addr = 14'h0400; word_count = 15'd4; pattern_seed = 32'h0; pattern_mode = 1'b1;
    start = 1'b1;
    done_seen = 0;
    tick();
    start = 1'b0;
    for (int k = 1; k < r_tick; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || sram_chipselect !== 1'b0) begin failures++;
      $display("FAIL midreset_status busy=%b done=%b cs=%b want 0 0 0", busy, done, sram_chipselect); end
    @(posedge clk); #2;
    repeat (6) tick();
    checks++; if (done_seen != 0) begin failures++; $display("FAIL midreset_done pulses=%0d want=0", done_seen); end
    obs_q.delete();
    push_expect(14'h0401, 1, 32'h0000_0077, 1'b0);
    run_job(14'h0401, 15'd1, 32'h0000_0077, 1'b0, 0, 0, 1'b0, cyc, to);
    checks++; if (to !== 1'b0 || cyc != job_len(1) || error !== 1'b0) begin failures++;
      $display("FAIL midreset_rerun cycles=%0d error=%b want %0d 0", cyc, error, job_len(1)); end
    checks++; if (obs_q.size() != exp_q.size() || (obs_q.size() != 0 && obs_q[0] !== exp_q[0])) begin failures++;
      $display("FAIL midreset_rerun_access count=%0d want=%0d", obs_q.size(), exp_q.size()); end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    @(posedge clk);
    #2;
    test_reset();
    test_basic();
`ifdef SRAM_FILL_VERIFY_EN
    test_corrupt();
`endif
    test_hold();
    test_out_of_range();
    test_zero_count();
    test_boundary_fit();
    test_back_to_back();
    test_reset_mid_job();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_fill_engine.md
SRAM_FILL_ENGINE -- requirements
Module: sram_fill_engine

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, meaning SRAM word-address width.
REQ-002 SHALL have parameter DEPTH, default 10240, meaning number of valid SRAM words.
REQ-003 SHALL have parameter DATA_W, default 32, meaning SRAM word width.
REQ-004 SHALL have port clk  in  1  meaning the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset  in  1  meaning synchronous, active-high reset.
REQ-006 SHALL have port start  in  1  meaning one-cycle job request, sampled only in IDLE.
REQ-007 SHALL have port base_addr  in  ADDR_W  meaning first word address of the job.
REQ-008 SHALL have port word_count  in  ADDR_W+1  meaning number of words to process.
REQ-009 SHALL have port pattern_seed  in  DATA_W  meaning the pattern start value.
REQ-010 SHALL have port pattern_mode  in  1  meaning 0 = constant seed, 1 = seed + word index (mod 2^DATA_W).
REQ-011 SHALL have port hold  in  1  meaning arbiter stall; no new SRAM access is issued while high.
REQ-012 SHALL have port busy, done, error  out  1 each  meaning job active / one-cycle completion pulse / sticky failure flag.
REQ-013 SHALL have port err_addr  out  ADDR_W  meaning address of the first failure.
REQ-014 SHALL have port err_count  out  ADDR_W+1  meaning saturating mismatch count.
REQ-015 SHALL have ports sram_address (ADDR_W), sram_byteenable (4), sram_chipselect, sram_write, sram_clken, sram_writedata (DATA_W)  out, and sram_readdata (DATA_W) in, meaning the SRAM slave port.

Function
REQ-016 SHALL implement states IDLE, FILL, VERIFY, DRAIN, DONE.
REQ-017 SHALL drive sram_byteenable = 4'b1111 and sram_clken = 1 at all times.
REQ-018 SHALL, in IDLE on start=1, latch all job inputs, clear error, err_addr and err_count, and move to FILL.
REQ-019 SHALL, when word_count = 0, go IDLE -> DONE with no SRAM access.
REQ-020 SHALL, when base_addr + word_count > DEPTH, go IDLE -> DONE with no SRAM access, set error = 1, and set err_addr = base_addr.
REQ-021 SHALL, in FILL with hold = 0, issue one write per cycle (chipselect = write = 1) at base_addr + i with the pattern value for index i, incrementing i.
REQ-022 SHALL, in FILL with hold = 1, drive chipselect = write = 0, keep i unchanged, and resume without skipping words.
REQ-023 SHALL leave FILL after word word_count-1 is written: to VERIFY (macro defined) or DONE (macro undefined).
REQ-024 SHALL, in VERIFY with hold = 0, issue one read per cycle (chipselect = 1, write = 0) from i = 0 upward.
REQ-025 SHALL compare sram_readdata one cycle after each read against the expected value for that index, delayed through a one-stage pipeline; this compare SHALL happen even if hold is high in that cycle.
REQ-026 SHALL, on each mismatch, increment err_count, saturating at all-ones; on the first mismatch of a job it SHALL set error = 1 and capture err_addr.
REQ-027 SHALL go VERIFY -> DRAIN after the last read is issued, and DRAIN -> DONE after that read's compare, one cycle later.
REQ-028 SHALL, in DONE, pulse done = 1 for exactly one cycle and return to IDLE on the next cycle.
REQ-029 SHALL hold busy = 1 in FILL, VERIFY and DRAIN, and busy = 0 otherwise.
REQ-030 SHALL ignore start while busy or in DONE.
REQ-031 SHALL keep error, err_addr and err_count stable from DONE until the next accepted start.

Reset
REQ-032 SHALL, on the edge with reset = 1, enter IDLE and drive busy, done, error, err_addr, err_count, sram_chipselect, sram_write, sram_address and sram_writedata to 0.
REQ-033 SHALL, on reset mid-job, abandon the job immediately with no done pulse; a pending compare SHALL be discarded.

Configuration
REQ-034 SHALL, with SRAM_FILL_VERIFY_EN defined, include the VERIFY/DRAIN read-back and compare logic.
REQ-035 SHALL, with SRAM_FILL_VERIFY_EN undefined, omit VERIFY/DRAIN and the compare logic entirely; err_count SHALL be tied to 0, and error SHALL be set only by REQ-020.

Verification
REQ-036 SHALL cover: base = 0x0100, count = 4, mode = 1, seed = 0xA0000000 -> writes 0xA0000000..0xA0000003 to 0x0100..0x0103, 4 reads, done once, error = 0.
REQ-037 SHALL cover: SRAM model corrupts address 0x0102 during verify -> error = 1, err_addr = 0x0102, err_count = 1.
REQ-038 SHALL cover: hold = 1 for 3 cycles mid-FILL (count = 8) -> exactly 8 writes, no address gap or repeat, job length grows by 3 cycles.
REQ-039 SHALL cover: base = 10238, count = 3 -> no chipselect, error = 1, err_addr = 10238, done pulse the cycle after start.
REQ-040 SHALL cover: reset asserted in the 2nd VERIFY cycle -> next cycle busy = 0, no done pulse; a new start with count = 1 then completes normally.
REQ-041 SHALL cover: count = 0 -> done pulse, zero SRAM accesses, error = 0.
